// File: rtl/elevator_car_controller_pkg.sv
// Shared types and constants for the elevator car controller slice.
package elevator_pkg;
    localparam int FLOOR_W    = 2;
    localparam int MAX_FLOORS = 4;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;
endpackage

// File: rtl/elevator_car_controller_if.sv
// Hall-side bundle: encoded call stream in, car status and pending calls out.
interface elevator_car_controller_if;
    import elevator_pkg::*;

    logic                  call_valid;
    logic [FLOOR_W-1:0]    floor_call;
    logic                  up_down_flag;
    logic                  door_hold;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  motor_up;
    logic                  motor_down;
    logic                  door_open;
    logic [MAX_FLOORS-1:0] pending_up;
    logic [MAX_FLOORS-1:0] pending_dn;
    logic                  served;

    modport master (
        output call_valid, floor_call, up_down_flag, door_hold,
        input  current_floor, motor_up, motor_down, door_open,
               pending_up, pending_dn, served
    );

    modport slave (
        input  call_valid, floor_call, up_down_flag, door_hold,
        output current_floor, motor_up, motor_down, door_open,
               pending_up, pending_dn, served
    );
endinterface

// File: rtl/elevator_car_controller_call_register.sv
// Per-floor, per-direction pending-call latches plus above/below/at summaries.
module elevator_call_register
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MAX_FLOORS-1:0] set_up_i,
    input  logic [MAX_FLOORS-1:0] set_dn_i,
    input  logic [MAX_FLOORS-1:0] clr_up_i,
    input  logic [MAX_FLOORS-1:0] clr_dn_i,
    output logic [MAX_FLOORS-1:0] pend_up_o,
    output logic [MAX_FLOORS-1:0] pend_dn_o,
    output logic [MAX_FLOORS-1:0] above_o,
    output logic [MAX_FLOORS-1:0] below_o,
    output logic [MAX_FLOORS-1:0] at_o
);
    localparam logic [MAX_FLOORS-1:0] FMASK = MAX_FLOORS'((1 << NUM_FLOORS) - 1);

    logic [MAX_FLOORS-1:0] up_q, dn_q, any_q;

    // A set in the same cycle as a clear wins; unserved floors never latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q <= '0;
            dn_q <= '0;
        end else begin
            up_q <= (up_q & ~clr_up_i) | (set_up_i & FMASK);
            dn_q <= (dn_q & ~clr_dn_i) | (set_dn_i & FMASK);
        end
    end

    assign any_q     = up_q | dn_q;
    assign pend_up_o = up_q;
    assign pend_dn_o = dn_q;

    for (genvar f = 0; f < MAX_FLOORS; f++) begin : g_fl
        localparam logic [MAX_FLOORS-1:0] LO = MAX_FLOORS'((1 << f) - 1);
        localparam logic [MAX_FLOORS-1:0] HI = ~LO & ~MAX_FLOORS'(1 << f);
        assign below_o[f] = |(any_q & LO);
        assign above_o[f] = |(any_q & HI);
        assign at_o[f]    = any_q[f];
    end
endmodule

// File: rtl/elevator_car_controller.sv
// Single-car SCAN controller: latches hall calls, times travel and door dwell.
// Define ELEV_DOOR_HOLD_EN to let door_hold keep the door open indefinitely.
module elevator_car_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic clk,
    input  logic rst_n,
    elevator_car_controller_if.slave bus
);
    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [FLOOR_W-1:0] TOP    = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [TW-1:0]      T_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]      D_LOAD = TW'(DOOR_CYCLES - 1);
`ifdef ELEV_DOOR_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    state_e               state_q, state_d;
    logic [FLOOR_W-1:0]   cur_q, cur_d, nf;
    logic                 dir_q, dir_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 served_q, served_d;
    logic                 mup_q, mdn_q, door_q;
    logic                 call_ok, call_dir, absorb, beyond, trav_bit, opp_bit, end_fl;
    logic [MAX_FLOORS-1:0] set_up, set_dn, clr_up, clr_dn;
    logic [MAX_FLOORS-1:0] pend_up, pend_dn, above, below, at_f;

    elevator_call_register #(.NUM_FLOORS(NUM_FLOORS)) u_calls (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_up_i (set_up),
        .set_dn_i (set_dn),
        .clr_up_i (clr_up),
        .clr_dn_i (clr_dn),
        .pend_up_o(pend_up),
        .pend_dn_o(pend_dn),
        .above_o  (above),
        .below_o  (below),
        .at_o     (at_f)
    );

    // End floors only have one meaningful call direction.
    always_comb begin
        call_ok  = bus.call_valid && (int'(bus.floor_call) < NUM_FLOORS);
        call_dir = (bus.floor_call == '0) ? DIR_UP :
                   (bus.floor_call == TOP) ? DIR_DN : bus.up_down_flag;
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        dir_d    = dir_q;
        tmr_d    = tmr_q;
        served_d = 1'b0;
        clr_up   = '0;
        clr_dn   = '0;
        set_up   = '0;
        set_dn   = '0;
        absorb   = 1'b0;
        nf       = (state_q == MOVE_DOWN) ? cur_q - FLOOR_W'(1) : cur_q + FLOOR_W'(1);
        beyond   = (state_q == MOVE_DOWN) ? below[nf] : above[nf];
        trav_bit = (state_q == MOVE_DOWN) ? pend_dn[nf] : pend_up[nf];
        opp_bit  = (state_q == MOVE_DOWN) ? pend_up[nf] : pend_dn[nf];
        end_fl   = (state_q == MOVE_DOWN) ? (nf == '0) : (nf == TOP);

        unique case (state_q)
            IDLE: begin
                absorb = call_ok && (bus.floor_call == cur_q);
                if (absorb || at_f[cur_q]) begin
                    state_d        = DOOR_OPEN;
                    tmr_d          = D_LOAD;
                    served_d       = 1'b1;
                    clr_up[cur_q]  = 1'b1;
                    clr_dn[cur_q]  = 1'b1;
                end else if (|(pend_up | pend_dn)) begin
                    tmr_d = T_LOAD;
                    if (dir_q == DIR_UP ? above[cur_q] : !below[cur_q]) begin
                        state_d = MOVE_UP;
                        dir_d   = DIR_UP;
                    end else begin
                        state_d = MOVE_DOWN;
                        dir_d   = DIR_DN;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else begin
                    cur_d = nf;
                    if (trav_bit || (opp_bit && !beyond) || end_fl) begin
                        state_d  = DOOR_OPEN;
                        tmr_d    = D_LOAD;
                        served_d = 1'b1;
                        absorb   = call_ok && (bus.floor_call == nf);
                        if (state_q == MOVE_UP || !beyond) clr_up[nf] = 1'b1;
                        if (state_q == MOVE_DOWN || !beyond) clr_dn[nf] = 1'b1;
                    end else begin
                        tmr_d = T_LOAD;
                    end
                end
            end
            DOOR_OPEN: begin
                absorb = call_ok && (bus.floor_call == cur_q);
                if (absorb || (HOLD_EN && bus.door_hold)) tmr_d = D_LOAD;
                else if (tmr_q == '0)                     state_d = IDLE;
                else                                      tmr_d = tmr_q - TW'(1);
            end
        endcase

        if (call_ok && !absorb) begin
            if (call_dir == DIR_UP) set_up[bus.floor_call] = 1'b1;
            else                    set_dn[bus.floor_call] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            dir_q    <= DIR_UP;
            tmr_q    <= '0;
            served_q <= 1'b0;
            mup_q    <= 1'b0;
            mdn_q    <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            dir_q    <= dir_d;
            tmr_q    <= tmr_d;
            served_q <= served_d;
            mup_q    <= (state_d == MOVE_UP);
            mdn_q    <= (state_d == MOVE_DOWN);
            door_q   <= (state_d == DOOR_OPEN);
        end
    end

    assign bus.current_floor = cur_q;
    assign bus.motor_up      = mup_q;
    assign bus.motor_down    = mdn_q;
    assign bus.door_open     = door_q;
    assign bus.pending_up    = pend_up;
    assign bus.pending_dn    = pend_dn;
    assign bus.served        = served_q;
endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_car_controller;
    import elevator_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cnt;

    elevator_car_controller_if bus();

    elevator_car_controller #(
        .NUM_FLOORS(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {17'd0, bus.current_floor, bus.motor_up, bus.motor_down, bus.door_open,
                bus.pending_up, bus.pending_dn, bus.served};
    endfunction

    // Advance one edge, sample 1ns later and check the output exclusivity rules.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("excl", 32'(!(bus.motor_up && bus.motor_down) &&
                           !((bus.motor_up || bus.motor_down) && bus.door_open)), 32'd1);
        end
    endtask

    task automatic strobe(input logic [1:0] f, input logic ud);
        bus.call_valid   = 1'b1;
        bus.floor_call   = f;
        bus.up_down_flag = ud;
        tick();
        bus.call_valid   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async", outs(), 32'd0);
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.call_valid = 1'b0; bus.floor_call = '0; bus.up_down_flag = 1'b0; bus.door_hold = 1'b0;
        #2;
        chk("rst_hold", outs(), 32'd0);
        tick(2);
        rst_n = 1'b1;

        // Idle after reset with no calls
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_outs", outs(), 32'd0);
            chk("idle_state", 32'(dut.state_q), 32'(IDLE));
        end

        // Floor 0 -> 2 up call
        strobe(2'd2, 1'b1);
        chk("t2_pend", 32'(bus.pending_up), 32'h4);
        chk("t2_mu0", 32'(bus.motor_up), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t2_mu", 32'(bus.motor_up), 32'd1);
            chk("t2_cur", 32'(bus.current_floor), (i < 4) ? 32'd0 : 32'd1);
            chk("t2_door", 32'(bus.door_open), 32'd0);
            tick();
        end
        chk("t2_arr", 32'({bus.current_floor, bus.motor_up, bus.door_open, bus.served}), 32'b10011);
        chk("t2_clr", 32'(bus.pending_up), 32'd0);
        tick();
        chk("t2_srv0", 32'({bus.door_open, bus.served}), 32'b10);
        tick();
        chk("t2_door3", 32'(bus.door_open), 32'd1);
        tick();
        chk("t2_close", 32'(bus.door_open), 32'd0);
        chk("t2_idle", 32'(dut.state_q), 32'(IDLE));

        // Call 3 down, then 1 up while travelling
        do_reset();
        strobe(2'd3, 1'b0);
        chk("t3_pdn", 32'(bus.pending_dn), 32'h8);
        tick();
        chk("t3_mu", 32'(bus.motor_up), 32'd1);
        tick();
        strobe(2'd1, 1'b1);
        chk("t3_pend", 32'({bus.pending_up, bus.pending_dn}), 32'h28);
        chk("t3_cur0", 32'(bus.current_floor), 32'd0);
        tick(2);
        chk("t3_stop1", 32'({bus.current_floor, bus.door_open, bus.served}), 32'b0111);
        chk("t3_pend1", 32'({bus.pending_up, bus.pending_dn}), 32'h08);
        tick(3);
        chk("t3_close1", 32'(bus.door_open), 32'd0);
        tick();
        chk("t3_mu2", 32'(bus.motor_up), 32'd1);
        tick(8);
        chk("t3_stop3", 32'({bus.current_floor, bus.door_open, bus.served}), 32'b1111);
        chk("t3_pend3", 32'({bus.pending_up, bus.pending_dn}), 32'h00);
        tick(3);
        chk("t3_close3", 32'(bus.door_open), 32'd0);

        // At floor 2 moving up: down-call 1 and up-call 3 -> serve 3, reverse, serve 1
        do_reset();
        strobe(2'd3, 1'b1);
        chk("t4_topdn", 32'({bus.pending_up, bus.pending_dn}), 32'h08);
        tick(9);
        chk("t4_at2", 32'({bus.current_floor, bus.motor_up}), 32'b101);
        strobe(2'd1, 1'b0);
        strobe(2'd3, 1'b1);
        chk("t4_pend", 32'({bus.pending_up, bus.pending_dn}), 32'h0A);
        tick(2);
        chk("t4_stop3", 32'({bus.current_floor, bus.door_open, bus.served}), 32'b1111);
        chk("t4_pend3", 32'(bus.pending_dn), 32'h2);
        tick(3);
        chk("t4_close3", 32'(bus.door_open), 32'd0);
        tick();
        chk("t4_rev", 32'({bus.motor_up, bus.motor_down}), 32'b01);
        tick(4);
        chk("t4_pass2", 32'({bus.current_floor, bus.motor_down, bus.served}), 32'b1010);
        tick(4);
        chk("t4_stop1", 32'({bus.current_floor, bus.door_open, bus.served}), 32'b0111);
        chk("t4_pend1", 32'({bus.pending_up, bus.pending_dn}), 32'h00);

        // Call to current floor while door timer is 1 restarts the dwell
        tick();
        strobe(2'd1, 1'b1);
        chk("t5_open", 32'({bus.door_open, bus.served}), 32'b10);
        chk("t5_nopend", 32'({bus.pending_up, bus.pending_dn}), 32'h00);
        tick();
        chk("t5_open2", 32'(bus.door_open), 32'd1);
        tick();
        chk("t5_open3", 32'(bus.door_open), 32'd1);
        tick();
        chk("t5_close", 32'(bus.door_open), 32'd0);

        // Call to current floor while idle opens the door directly
        strobe(2'd1, 1'b0);
        chk("t6_open", 32'({bus.door_open, bus.served}), 32'b11);
        chk("t6_nopend", 32'({bus.pending_up, bus.pending_dn}), 32'h00);
        tick(3);
        chk("t6_close", 32'(bus.door_open), 32'd0);

        // Floor 0 always latches as up; reset while moving down
        strobe(2'd0, 1'b0);
        chk("t7_bot_up", 32'({bus.pending_up, bus.pending_dn}), 32'h10);
        tick();
        chk("t7_md", 32'(bus.motor_down), 32'd1);
        tick();
        do_reset();
        tick();
        chk("t7_after", outs(), 32'd0);

        // Door hold for 10 door cycles
        strobe(2'd0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0)  bus.door_hold = 1'b1;
            if (i == 10) bus.door_hold = 1'b0;
            if (bus.door_open) cnt++;
            tick();
        end
`ifdef ELEV_DOOR_HOLD_EN
        chk("t8_hold", 32'(cnt), 32'd13);
`else
        chk("t8_nohold", 32'(cnt), 32'd3);
`endif
        chk("t8_idle", 32'(dut.state_q), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
